// File: rtl/mem_pkg.sv
// Definitions shared by the RAM-side blocks: transaction FSM encoding and the read byte-lane mask.
package mem_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        CAPTURE = 2'd2,
        RESP    = 2'd3
    } mem_state_e;

    localparam logic [15:0] BYTE_MASK = 16'h00FF;

endpackage

// File: rtl/mem_master.sv
// Initiator for the on-chip RAM: one load/store at a time, sequenced onto the
// single-cycle store / registered-read RAM port, with a response handshake back to the core.
module mem_master
    import mem_pkg::*;
#(
    parameter int ADDR_WIDTH = 12
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic                  req_byte,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [15:0]           req_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [15:0]           rsp_rdata,
    output logic                  rsp_unaligned,
    output logic                  mem_store,
    output logic                  mem_bytemode,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic [15:0]           mem_wdata,
    input  logic [15:0]           mem_rdata
);

    mem_state_e            state_q, state_d;
    logic                  write_q, write_d;
    logic                  byte_q, byte_d;
    logic                  unal_q, unal_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [15:0]           wdata_q, wdata_d;
    logic [15:0]           rdata_q, rdata_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            write_q <= 1'b0;
            byte_q  <= 1'b0;
            unal_q  <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            write_q <= write_d;
            byte_q  <= byte_d;
            unal_q  <= unal_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        write_d   = write_q;
        byte_d    = byte_q;
        unal_d    = unal_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        rdata_d   = rdata_q;
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        mem_store = 1'b0;

        case (state_q)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    write_d = req_write;
                    byte_d  = req_byte;
                    wdata_d = req_wdata;
                    unal_d  = !req_byte && req_addr[0];
                    // Word accesses are forced onto the even address; no wrap/increment needed.
                    addr_d  = req_byte ? req_addr : {req_addr[ADDR_WIDTH-1:1], 1'b0};
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                mem_store = write_q;
                if (write_q) begin
                    rdata_d = '0;
                    state_d = RESP;
                end else begin
                    state_d = CAPTURE;
                end
            end
            CAPTURE: begin
                // The RAM mirrors the odd bank on [15:8] in byte mode, so mask it off.
                rdata_d = byte_q ? (mem_rdata & BYTE_MASK) : mem_rdata;
                state_d = RESP;
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign mem_address   = addr_q;
    assign mem_bytemode  = byte_q;
    assign mem_wdata     = wdata_q;
    assign rsp_rdata     = rdata_q;
    assign rsp_unaligned = unal_q;

endmodule

// File: tb/tb_mem_master.sv
// Scoreboard bench for mem_master against a behavioural registered-read RAM and a byte-array reference.
module tb_mem_master;

    localparam int AW = 12;

    logic          clk = 1'b0;
    logic          rst;
    logic          req_valid, req_ready, req_write, req_byte;
    logic [AW-1:0] req_addr;
    logic [15:0]   req_wdata;
    logic          rsp_valid, rsp_ready, rsp_unaligned;
    logic [15:0]   rsp_rdata;
    logic          mem_store, mem_bytemode;
    logic [AW-1:0] mem_address;
    logic [15:0]   mem_wdata, mem_rdata;

    logic          rnd_mode = 1'b0;
    logic          rr_force = 1'b1;
    logic          rnd_bit = 1'b1;
    logic          ram_init = 1'b1;

    typedef struct packed {
        logic [15:0] rdata;
        logic        unal;
    } exp_t;

    exp_t       sbq[$];
    int         n_chk = 0;
    int         n_pass = 0;
    int         st_cnt = 0;
    logic [7:0] ram     [0:(1<<AW)-1];
    logic [7:0] ref_mem [0:(1<<AW)-1];

    always #5 clk = ~clk;

    mem_master #(.ADDR_WIDTH(AW)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_byte(req_byte), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_unaligned(rsp_unaligned),
        .mem_store(mem_store), .mem_bytemode(mem_bytemode), .mem_address(mem_address),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    function automatic logic [7:0] seed_byte(input int i);
        logic [31:0] t;
        t = i * 37 + 91;
        return t[7:0];
    endfunction

    // RAM model: byte mode puts the odd bank on [15:8], like the real part.
    logic [AW-1:0] ram_ev, ram_od;
    assign ram_ev = {mem_address[AW-1:1], 1'b0};
    assign ram_od = {mem_address[AW-1:1], 1'b1};

    always @(posedge clk) begin
        if (ram_init) begin
            for (int i = 0; i < (1 << AW); i++) ram[i] <= seed_byte(i);
        end else if (mem_store) begin
            if (mem_bytemode) ram[mem_address] <= mem_wdata[7:0];
            else begin
                ram[ram_ev] <= mem_wdata[7:0];
                ram[ram_od] <= mem_wdata[15:8];
            end
        end
        mem_rdata <= mem_bytemode ? {ram[ram_od], ram[mem_address]} : {ram[ram_od], ram[ram_ev]};
    end

    always @(posedge clk) rnd_bit <= 1'($urandom_range(0, 1));
    assign rsp_ready = rnd_mode ? rnd_bit : rr_force;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (mem_store) st_cnt++;
            if (rsp_valid) begin
                check("rdy_in_resp", {31'd0, req_ready}, 32'd0);
                if (rsp_ready) begin
                    check("sb_nonempty", {31'd0, sbq.size() != 0}, 32'd1);
                    if (sbq.size() != 0) begin
                        exp_t e;
                        e = sbq.pop_front();
                        check("rsp_rdata", {16'd0, rsp_rdata}, {16'd0, e.rdata});
                        check("rsp_unal", {31'd0, rsp_unaligned}, {31'd0, e.unal});
                    end
                end
            end
        end
    end

    task automatic do_req(input logic w, input logic b, input logic [AW-1:0] a, input logic [15:0] d);
        exp_t          e;
        logic [AW-1:0] ev, od;
        int            n;
        ev = {a[AW-1:1], 1'b0};
        od = {a[AW-1:1], 1'b1};
        e.unal = !b && a[0];
        if (w) begin
            e.rdata = 16'h0000;
            if (b) ref_mem[a] = d[7:0];
            else begin
                ref_mem[ev] = d[7:0];
                ref_mem[od] = d[15:8];
            end
        end else begin
            e.rdata = b ? {8'h00, ref_mem[a]} : {ref_mem[od], ref_mem[ev]};
        end
        sbq.push_back(e);
        req_write = w;
        req_byte  = b;
        req_addr  = a;
        req_wdata = d;
        req_valid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!req_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) check("req_tmo", {31'd0, req_ready}, 32'd1);
        @(posedge clk);
        #1 req_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (sbq.size() != 0 && n < 500) begin
            @(negedge clk);
            n++;
        end
        check("drain", sbq.size(), 32'd0);
        @(posedge clk);
        #1;
    endtask

    // Called right after accept: counts negedges until rsp_valid shows up.
    task automatic lat_check(input string tag, input int exp_n, input logic [15:0] exp_d);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!rsp_valid && n < 20);
        check({tag, "_lat"}, n, exp_n);
        check({tag, "_data"}, {16'd0, rsp_rdata}, {16'd0, exp_d});
        wait_drain();
    endtask

    task automatic check_reset(input string p);
        check({p, "_req_ready"}, {31'd0, req_ready}, 32'd1);
        check({p, "_rsp_valid"}, {31'd0, rsp_valid}, 32'd0);
        check({p, "_rsp_rdata"}, {16'd0, rsp_rdata}, 32'd0);
        check({p, "_rsp_unal"}, {31'd0, rsp_unaligned}, 32'd0);
        check({p, "_mem_store"}, {31'd0, mem_store}, 32'd0);
        check({p, "_mem_byte"}, {31'd0, mem_bytemode}, 32'd0);
        check({p, "_mem_addr"}, {20'd0, mem_address}, 32'd0);
        check({p, "_mem_wdata"}, {16'd0, mem_wdata}, 32'd0);
    endtask

    task automatic wait_valid();
        int n;
        n = 0;
        while (!rsp_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("wait_valid", {31'd0, rsp_valid}, 32'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int          s0;
        logic        stable;
        logic [15:0] v, d;

        for (int i = 0; i < (1 << AW); i++) ref_mem[i] = seed_byte(i);
        rst = 1'b1;
        req_valid = 1'b0; req_write = 1'b0; req_byte = 1'b0;
        req_addr = '0; req_wdata = '0;
        repeat (2) @(posedge clk);
        #1 ram_init = 1'b0;
        check_reset("rst0");
        @(negedge clk) rst = 1'b0;
        @(posedge clk);
        #1;

        // word store then word load
        s0 = st_cnt;
        do_req(1'b1, 1'b0, 12'h010, 16'h1234);
        wait_drain();
        check("st_pulse", st_cnt - s0, 32'd1);
        do_req(1'b0, 1'b0, 12'h010, 16'h0000);
        lat_check("wld", 3, 16'h1234);

        // byte store, byte load, word load
        s0 = st_cnt;
        do_req(1'b1, 1'b1, 12'h011, 16'h55AB);
        lat_check("bst", 2, 16'h0000);
        check("bst_pulse", st_cnt - s0, 32'd1);
        do_req(1'b0, 1'b1, 12'h011, 16'h0000);
        lat_check("bld", 3, 16'h00AB);
        do_req(1'b0, 1'b0, 12'h010, 16'h0000);
        lat_check("wld2", 3, 16'hAB34);

        // unaligned word load
        do_req(1'b0, 1'b0, 12'h011, 16'h0000);
        check("ua_addr", {20'd0, mem_address}, 32'h010);
        lat_check("ua", 3, 16'hAB34);

        // all-ones byte address on a word load
        do_req(1'b0, 1'b0, 12'hFFF, 16'h0000);
        check("wrap_addr", {20'd0, mem_address}, 32'hFFE);
        lat_check("wrap", 3, {seed_byte(12'hFFF), seed_byte(12'hFFE)});

        // response back-pressure
        rr_force = 1'b0;
        do_req(1'b0, 1'b0, 12'h020, 16'h0000);
        wait_valid();
        v = rsp_rdata;
        check("hold_data", {16'd0, v}, {16'd0, ref_mem[12'h021], ref_mem[12'h020]});
        s0 = st_cnt;
        stable = 1'b1;
        repeat (10) begin
            @(negedge clk);
            if (rsp_valid !== 1'b1 || rsp_rdata !== v || req_ready !== 1'b0) stable = 1'b0;
        end
        check("hold_stable", {31'd0, stable}, 32'd1);
        check("hold_nostore", st_cnt - s0, 32'd0);
        @(posedge clk);
        #1 rr_force = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("hold_done", {31'd0, rsp_valid}, 32'd0);
        check("hold_sb", sbq.size(), 32'd0);
        @(posedge clk);
        #1;

        // reset during ISSUE of a store (data equals current contents, so commit is moot)
        d = {ref_mem[12'h031], ref_mem[12'h030]};
        do_req(1'b1, 1'b0, 12'h030, d);
        check("iss_store", {31'd0, mem_store}, 32'd1);
        rst = 1'b1;
        #1 check_reset("rst_iss");
        sbq.delete();
        @(negedge clk) rst = 1'b0;
        @(posedge clk);
        #1;
        do_req(1'b0, 1'b0, 12'h030, 16'h0000);
        lat_check("post_iss", 3, d);

        // reset during RESP of a load
        rr_force = 1'b0;
        do_req(1'b0, 1'b1, 12'h013, 16'h0000);
        wait_valid();
        rst = 1'b1;
        #1 check_reset("rst_resp");
        sbq.delete();
        rr_force = 1'b1;
        @(negedge clk) rst = 1'b0;
        @(posedge clk);
        #1;
        do_req(1'b1, 1'b0, 12'h040, 16'hBEEF);
        wait_drain();
        do_req(1'b0, 1'b0, 12'h040, 16'h0000);
        lat_check("post_resp", 3, 16'hBEEF);

        // random traffic against the reference model
        rnd_mode = 1'b1;
        for (int i = 0; i < 200; i++) begin
            do_req(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                   12'($urandom_range(0, 63)), 16'($urandom));
        end
        wait_drain();
        rnd_mode = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
